// File: rtl/fp_mul_pipe_pkg.sv
// Shared float formats, operand classes and flag positions
// for the pipelined floating-point multiplier.
package fp_mul_pipe_pkg;

   localparam int FLOAT32_EXP_WIDTH = 8;
   localparam int FLOAT32_SIG_WIDTH = 23;

   typedef struct packed {
      logic                         sign;
      logic [FLOAT32_EXP_WIDTH-1:0] exp;
      logic [FLOAT32_SIG_WIDTH-1:0] frac;
   } float32_t;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   localparam int FP_FLAG_INVALID   = 2;
   localparam int FP_FLAG_OVERFLOW  = 1;
   localparam int FP_FLAG_UNDERFLOW = 0;

   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round (RNE or truncate) and pack one product,
// resolving special classes and overflow/underflow.
module fp_round_pack
   import fp_mul_pipe_pkg::*;
#(
   parameter int EXP_WIDTH = FLOAT32_EXP_WIDTH,
   parameter int SIG_WIDTH = FLOAT32_SIG_WIDTH,
   parameter bit TRUNC     = 1'b0
) (
   input  logic                         sign,
   input  logic [1:0]                   cls,
   input  logic                         inv,
   input  logic [EXP_WIDTH+1:0]         exp,
   input  logic [2*SIG_WIDTH+1:0]       prod,
   output logic [EXP_WIDTH+SIG_WIDTH:0] res,
   output logic [2:0]                   flags
);

   localparam int M  = SIG_WIDTH + 1;
   localparam int P  = 2 * M;
   localparam int XW = EXP_WIDTH + 2;
   localparam logic signed [XW-1:0] EMAX =
      XW'((1 << EXP_WIDTH) - 1);
   localparam logic signed [XW-1:0] EZERO = '0;

   logic [P-1:0]           norm;
   logic signed [XW-1:0]   e1;
   logic signed [XW-1:0]   e2;
   logic [M-1:0]           mant;
   logic                   g;
   logic                   r;
   logic                   st;
   logic                   inc;
   logic [M:0]             mr;
   logic [SIG_WIDTH-1:0]   frac;

   always_comb begin
      norm = prod[P-1] ? prod : {prod[P-2:0], 1'b0};
      e1   = $signed(exp)
           + $signed({{(XW-1){1'b0}}, prod[P-1]});
      mant = norm[P-1 -: M];
      g    = norm[M-1];
      r    = norm[M-2];
      st   = |norm[M-3:0];
      inc  = !TRUNC && g && (r || st || mant[0]);
      mr   = {1'b0, mant} + {{M{1'b0}}, inc};
      // a carry out leaves 10..0, so the shifted fraction is zero
      frac = mr[M] ? mr[SIG_WIDTH:1] : mr[SIG_WIDTH-1:0];
      e2   = e1 + $signed({{(XW-1){1'b0}}, mr[M]});
      res   = '0;
      flags = '0;
      case (fp_class_e'(cls))
         FP_NAN: begin
            res = {sign, {EXP_WIDTH{1'b1}}, 1'b1,
                   {(SIG_WIDTH-1){1'b0}}};
            flags[FP_FLAG_INVALID] = inv;
         end
         FP_INF:
            res = {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
         FP_ZERO:
            res = {sign, {(EXP_WIDTH+SIG_WIDTH){1'b0}}};
         default: begin
            unique case (1'b1)
               (e2 >= EMAX): begin
                  res = {sign, {EXP_WIDTH{1'b1}},
                         {SIG_WIDTH{1'b0}}};
                  flags[FP_FLAG_OVERFLOW] = 1'b1;
               end
               (e2 <= EZERO): begin
                  res = {sign, {(EXP_WIDTH+SIG_WIDTH){1'b0}}};
                  flags[FP_FLAG_UNDERFLOW] = 1'b1;
               end
               default:
                  res = {sign, e2[EXP_WIDTH-1:0], frac};
            endcase
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack/classify,
// significand multiply, round/pack; whole pipe stalls on adv.
module fp_mul_pipe
   import fp_mul_pipe_pkg::*;
#(
   parameter int EXP_WIDTH   = FLOAT32_EXP_WIDTH,
   parameter int SIG_WIDTH   = FLOAT32_SIG_WIDTH,
   parameter int APPROX_BITS = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [EXP_WIDTH+SIG_WIDTH:0] in_a,
   input  logic [EXP_WIDTH+SIG_WIDTH:0] in_b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_WIDTH+SIG_WIDTH:0] out_res,
   output logic [2:0]                   out_flags
);

   localparam int W    = 1 + EXP_WIDTH + SIG_WIDTH;
   localparam int M    = SIG_WIDTH + 1;
   localparam int P    = 2 * M;
   localparam int XW   = EXP_WIDTH + 2;
   localparam int BIAS = fp_bias(EXP_WIDTH);
   localparam logic [SIG_WIDTH-1:0] FMASK =
      {SIG_WIDTH{1'b1}} << APPROX_BITS;

   typedef struct packed {
      logic          valid;
      logic          sign;
      fp_class_e     cls;
      logic          inv;
      logic [XW-1:0] exp;
      logic [M-1:0]  ma;
      logic [M-1:0]  mb;
   } s1_t;

   typedef struct packed {
      logic          valid;
      logic          sign;
      fp_class_e     cls;
      logic          inv;
      logic [XW-1:0] exp;
      logic [P-1:0]  prod;
   } s2_t;

   s1_t        s1_d;
   s1_t        s1_q;
   s2_t        s2_d;
   s2_t        s2_q;
   logic       adv;
   fp_class_e  ca;
   fp_class_e  cb;
   logic [W-1:0] rp_res;
   logic [2:0]   rp_flags;

   function automatic fp_class_e classify(
      input logic [EXP_WIDTH-1:0] e,
      input logic [SIG_WIDTH-1:0] f
   );
      fp_class_e c;
      unique case (1'b1)
         (e == '0):          c = FP_ZERO;
         (&e && f == '0):    c = FP_INF;
         (&e && f != '0):    c = FP_NAN;
         default:            c = FP_NORM;
      endcase
      return c;
   endfunction

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign ca = classify(in_a[W-2:SIG_WIDTH], in_a[SIG_WIDTH-1:0]);
   assign cb = classify(in_b[W-2:SIG_WIDTH], in_b[SIG_WIDTH-1:0]);

   always_comb begin
      s1_d       = '0;
      s1_d.valid = in_valid;
      s1_d.sign  = in_a[W-1] ^ in_b[W-1];
      s1_d.exp   = {2'b00, in_a[W-2:SIG_WIDTH]}
                 + {2'b00, in_b[W-2:SIG_WIDTH]}
                 - XW'(BIAS);
      s1_d.ma    = {1'b1, in_a[SIG_WIDTH-1:0] & FMASK};
      s1_d.mb    = {1'b1, in_b[SIG_WIDTH-1:0] & FMASK};
      s1_d.cls   = FP_NORM;
      if (ca == FP_NAN || cb == FP_NAN) begin
         s1_d.cls = FP_NAN;
      end else if ((ca == FP_INF && cb == FP_ZERO) ||
                   (ca == FP_ZERO && cb == FP_INF)) begin
         s1_d.cls = FP_NAN;
         s1_d.inv = 1'b1;
      end else if (ca == FP_INF || cb == FP_INF) begin
         s1_d.cls = FP_INF;
      end else if (ca == FP_ZERO || cb == FP_ZERO) begin
         s1_d.cls = FP_ZERO;
      end
   end

   always_comb begin
      s2_d.valid = s1_q.valid;
      s2_d.sign  = s1_q.sign;
      s2_d.cls   = s1_q.cls;
      s2_d.inv   = s1_q.inv;
      s2_d.exp   = s1_q.exp;
      s2_d.prod  = P'(s1_q.ma) * P'(s1_q.mb);
   end

   fp_round_pack #(
      .EXP_WIDTH (EXP_WIDTH),
      .SIG_WIDTH (SIG_WIDTH),
      .TRUNC     (APPROX_BITS > 0)
   ) u_round_pack (
      .sign  (s2_q.sign),
      .cls   (s2_q.cls),
      .inv   (s2_q.inv),
      .exp   (s2_q.exp),
      .prod  (s2_q.prod),
      .res   (rp_res),
      .flags (rp_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_flags <= '0;
      end else if (adv) begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         out_valid <= s2_q.valid;
         out_res   <= rp_res;
         out_flags <= rp_flags;
      end
   end

endmodule
